// File: rtl/cpu_mem_mmio.sv
// Shared dual-port word RAM for the CPU fetch and load/store ports, plus a small
// MMIO window (GPIO, free-running cycle counter, sticky status) on the load/store port.
module cpu_mem_mmio #(
    parameter int            IW        = 32,
    parameter int            MEM_WORDS = 2048,
    parameter logic [IW-1:0] MMIO_BASE = 32'h0000_A000
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [IW-1:0] i_pc_addr,
    input  logic          i_pc_rd,
    input  logic [3:0]    i_pc_byte_en,
    output logic [IW-1:0] o_pc_rddata,
    input  logic [IW-1:0] i_ldst_addr,
    input  logic          i_ldst_rd,
    input  logic          i_ldst_wr,
    input  logic [IW-1:0] i_ldst_wrdata,
    input  logic [3:0]    i_ldst_byte_en,
    output logic [IW-1:0] o_ldst_rddata,
    output logic [IW-1:0] o_gpio
);

    localparam int AW = $clog2(MEM_WORDS);

    typedef enum logic [1:0] {
        OFF_GPIO   = 2'd0,
        OFF_CYCLE  = 2'd1,
        OFF_RSVD   = 2'd2,
        OFF_STATUS = 2'd3
    } mmio_off_t;

    function automatic logic [IW-1:0] lane_merge(input logic [IW-1:0] old_word,
                                                 input logic [IW-1:0] new_word,
                                                 input logic [3:0]    lanes);
        logic [IW-1:0] merged;
        merged = old_word;
        for (int b = 0; b < 4; b++) begin
            if (lanes[b]) merged[8*b +: 8] = new_word[8*b +: 8];
        end
        return merged;
    endfunction

    logic [IW-1:0] mem [MEM_WORDS];

    logic [AW-1:0] pc_idx;
    logic [AW-1:0] ldst_idx;
    logic          ldst_is_mmio;
    mmio_off_t     mmio_off;
    logic          wr_any;
    logic          rd_only;
    logic          ram_wr;
    logic          mmio_wr;
    logic          mmio_rd;
    logic [IW-1:0] mmio_rdata;

    logic [IW-1:0] cycle_cnt;
    logic [1:0]    status;
    logic [1:0]    status_set;
    logic [1:0]    status_clr;

    logic          sel_mmio_p0;
    logic [IW-1:0] ram_rd_p0;
    logic [IW-1:0] mmio_rd_p0;

    // Fetch byte-enables and sub-word address bits carry no meaning for word accesses.
    logic unused_ok;
    assign unused_ok = ^{i_pc_byte_en, i_pc_addr[1:0], i_pc_addr[IW-1:AW+2], i_ldst_addr[1:0]};

    // Address decode and access qualification
    always_comb begin
        pc_idx       = i_pc_addr[AW+1:2];
        ldst_idx     = i_ldst_addr[AW+1:2];
        ldst_is_mmio = (i_ldst_addr[IW-1:4] == MMIO_BASE[IW-1:4]);
        mmio_off     = mmio_off_t'(i_ldst_addr[3:2]);
        wr_any       = i_ldst_wr && (i_ldst_byte_en != 4'b0000);
        rd_only      = i_ldst_rd && !i_ldst_wr;
        ram_wr       = wr_any && !ldst_is_mmio;
        mmio_wr      = wr_any && ldst_is_mmio;
        mmio_rd      = rd_only && ldst_is_mmio;
    end

    always_comb begin
        mmio_rdata = '0;
        case (mmio_off)
            OFF_GPIO:   mmio_rdata = o_gpio;
            OFF_CYCLE:  mmio_rdata = cycle_cnt;
            OFF_RSVD:   mmio_rdata = '0;
            OFF_STATUS: mmio_rdata = {{(IW-2){1'b0}}, status};
            default:    mmio_rdata = '0;
        endcase
    end

    always_comb begin
        status_set    = 2'b00;
        status_clr    = 2'b00;
        status_set[0] = mmio_wr && (mmio_off == OFF_CYCLE);
        status_set[1] = (mmio_wr || mmio_rd) && (mmio_off == OFF_RSVD);
        if (mmio_wr && (mmio_off == OFF_STATUS) && i_ldst_byte_en[0]) begin
            status_clr = i_ldst_wrdata[1:0];
        end
    end

    // RAM write port; contents survive reset
    always_ff @(posedge clk) begin
        if (ram_wr) begin
            mem[ldst_idx] <= lane_merge(mem[ldst_idx], i_ldst_wrdata, i_ldst_byte_en);
        end
    end

    // Fetch read: nonblocking capture gives read-before-write on a same-word store
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            o_pc_rddata <= '0;
        end else if (i_pc_rd) begin
            o_pc_rddata <= mem[pc_idx];
        end
    end

    // Load stage p0: source select registered with the data, muxed after the flops
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sel_mmio_p0 <= 1'b0;
            ram_rd_p0   <= '0;
            mmio_rd_p0  <= '0;
        end else if (rd_only) begin
            sel_mmio_p0 <= ldst_is_mmio;
            if (ldst_is_mmio) begin
                mmio_rd_p0 <= mmio_rdata;
            end else begin
                ram_rd_p0 <= mem[ldst_idx];
            end
        end
    end

    assign o_ldst_rddata = sel_mmio_p0 ? mmio_rd_p0 : ram_rd_p0;

    // MMIO registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            o_gpio    <= '0;
            cycle_cnt <= '0;
            status    <= 2'b00;
        end else begin
            if (mmio_wr && (mmio_off == OFF_GPIO)) begin
                o_gpio <= lane_merge(o_gpio, i_ldst_wrdata, i_ldst_byte_en);
            end
            if (mmio_wr && (mmio_off == OFF_CYCLE)) begin
                cycle_cnt <= '0;
            end else begin
                cycle_cnt <= cycle_cnt + {{(IW-1){1'b0}}, 1'b1};
            end
            status <= (status & ~status_clr) | status_set;
        end
    end

endmodule

// File: tb/tb_cpu_mem_mmio.sv
// Directed bench for cpu_mem_mmio: reset, byte lanes, collision, counter,
// GPIO/status/reserved, aliasing and simultaneous rd+wr.
module tb_cpu_mem_mmio;

    localparam int          IW        = 32;
    localparam int          MEM_WORDS = 2048;
    localparam logic [31:0] MMIO_BASE = 32'h0000_A000;

    logic          clk;
    logic          reset;
    logic [IW-1:0] i_pc_addr;
    logic          i_pc_rd;
    logic [3:0]    i_pc_byte_en;
    logic [IW-1:0] o_pc_rddata;
    logic [IW-1:0] i_ldst_addr;
    logic          i_ldst_rd;
    logic          i_ldst_wr;
    logic [IW-1:0] i_ldst_wrdata;
    logic [3:0]    i_ldst_byte_en;
    logic [IW-1:0] o_ldst_rddata;
    logic [IW-1:0] o_gpio;

    int checks = 0;
    int errors = 0;

    cpu_mem_mmio #(
        .IW        (IW),
        .MEM_WORDS (MEM_WORDS),
        .MMIO_BASE (MMIO_BASE)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .i_pc_addr      (i_pc_addr),
        .i_pc_rd        (i_pc_rd),
        .i_pc_byte_en   (i_pc_byte_en),
        .o_pc_rddata    (o_pc_rddata),
        .i_ldst_addr    (i_ldst_addr),
        .i_ldst_rd      (i_ldst_rd),
        .i_ldst_wr      (i_ldst_wr),
        .i_ldst_wrdata  (i_ldst_wrdata),
        .i_ldst_byte_en (i_ldst_byte_en),
        .o_ldst_rddata  (o_ldst_rddata),
        .o_gpio         (o_gpio)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [IW-1:0] obs, input logic [IW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs change 1 time unit after each rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic ld_write(input logic [IW-1:0] addr, input logic [IW-1:0] data, input logic [3:0] be);
        i_ldst_addr    = addr;
        i_ldst_wrdata  = data;
        i_ldst_byte_en = be;
        i_ldst_wr      = 1'b1;
        cyc();
        i_ldst_wr      = 1'b0;
    endtask

    task automatic ld_read(input logic [IW-1:0] addr);
        i_ldst_addr = addr;
        i_ldst_rd   = 1'b1;
        cyc();
        i_ldst_rd   = 1'b0;
    endtask

    task automatic pc_read(input logic [IW-1:0] addr);
        i_pc_addr = addr;
        i_pc_rd   = 1'b1;
        cyc();
        i_pc_rd   = 1'b0;
    endtask

    initial begin
        reset          = 1'b0;
        i_pc_addr      = '0;
        i_pc_rd        = 1'b0;
        i_pc_byte_en   = 4'hF;
        i_ldst_addr    = '0;
        i_ldst_rd      = 1'b0;
        i_ldst_wr      = 1'b0;
        i_ldst_wrdata  = '0;
        i_ldst_byte_en = 4'hF;
        repeat (2) cyc();
        reset = 1'b1;
        cyc();
        chk("por_pc", o_pc_rddata, 32'h0);
        chk("por_ldst", o_ldst_rddata, 32'h0);
        chk("por_gpio", o_gpio, 32'h0);

        // Preload RAM word 5 and make GPIO / outputs nonzero before the mid-read reset
        ld_write(32'h14, 32'hDEADBEEF, 4'hF);
        ld_write(MMIO_BASE, 32'h12345678, 4'hF);
        ld_read(32'h14);
        chk("pre_rst_ldst", o_ldst_rddata, 32'hDEADBEEF);

        i_pc_addr   = 32'h14;
        i_pc_rd     = 1'b1;
        i_ldst_addr = 32'h14;
        i_ldst_rd   = 1'b1;
        #2;
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        i_pc_rd   = 1'b0;
        i_ldst_rd = 1'b0;
        chk("rst_pc", o_pc_rddata, 32'h0);
        chk("rst_ldst", o_ldst_rddata, 32'h0);
        chk("rst_gpio", o_gpio, 32'h0);

        i_ldst_addr = MMIO_BASE + 32'h4;
        i_ldst_rd   = 1'b1;
        reset       = 1'b1;
        cyc();
        i_ldst_rd   = 1'b0;
        chk("rst_cycle0", o_ldst_rddata, 32'h0);
        chk("rst_pc_hold", o_pc_rddata, 32'h0);
        pc_read(32'h14);
        chk("ram_survives", o_pc_rddata, 32'hDEADBEEF);

        // Byte-enabled store
        ld_write(32'h14, 32'h11223344, 4'hF);
        ld_write(32'h14, 32'hAABBCCDD, 4'b0101);
        ld_read(32'h14);
        chk("be_ldst", o_ldst_rddata, 32'h11BB33DD);
        pc_read(32'h14);
        chk("be_pc", o_pc_rddata, 32'h11BB33DD);

        // Same-word collision on word 8
        ld_write(32'h20, 32'h0, 4'hF);
        i_pc_addr      = 32'h20;
        i_pc_rd        = 1'b1;
        i_ldst_addr    = 32'h20;
        i_ldst_wrdata  = 32'hCAFEF00D;
        i_ldst_byte_en = 4'hF;
        i_ldst_wr      = 1'b1;
        cyc();
        i_pc_rd   = 1'b0;
        i_ldst_wr = 1'b0;
        chk("coll_old", o_pc_rddata, 32'h0);
        pc_read(32'h20);
        chk("coll_new", o_pc_rddata, 32'hCAFEF00D);

        // Counter clear and status
        ld_write(MMIO_BASE + 32'h4, 32'hDEAD, 4'hF);
        repeat (9) cyc();
        ld_read(MMIO_BASE + 32'h4);
        chk("cycle_9", o_ldst_rddata, 32'd9);
        ld_read(MMIO_BASE + 32'hC);
        chk("status_1", o_ldst_rddata, 32'h1);
        ld_write(MMIO_BASE + 32'hC, 32'h1, 4'hF);
        ld_read(MMIO_BASE + 32'hC);
        chk("status_clr", o_ldst_rddata, 32'h0);

        // GPIO lanes
        ld_write(MMIO_BASE, 32'h000000FF, 4'b0001);
        chk("gpio_ff", o_gpio, 32'h000000FF);
        ld_write(MMIO_BASE, 32'hAABBCCDD, 4'b0010);
        chk("gpio_lane1", o_gpio, 32'h0000CCFF);
        ld_read(MMIO_BASE);
        chk("gpio_rd", o_ldst_rddata, 32'h0000CCFF);

        // Reserved offset
        ld_read(MMIO_BASE + 32'h8);
        chk("rsvd_rd", o_ldst_rddata, 32'h0);
        ld_read(MMIO_BASE + 32'hC);
        chk("status_2", o_ldst_rddata, 32'h2);

        // Zero byte-enable store is a no-op
        ld_write(MMIO_BASE + 32'hC, 32'h2, 4'hF);
        ld_write(MMIO_BASE + 32'h4, 32'h0, 4'b0000);
        ld_write(MMIO_BASE, 32'hFFFFFFFF, 4'b0000);
        chk("be0_gpio", o_gpio, 32'h0000CCFF);
        ld_read(MMIO_BASE + 32'hC);
        chk("be0_status", o_ldst_rddata, 32'h0);

        // Aliasing above the RAM size
        ld_write(4 * MEM_WORDS, 32'h55, 4'hF);
        ld_read(32'h0);
        chk("alias_ldst", o_ldst_rddata, 32'h55);
        pc_read(32'h0);
        chk("alias_pc", o_pc_rddata, 32'h55);

        // rd and wr together: write lands, read ignored
        i_ldst_addr    = 32'h0;
        i_ldst_wrdata  = 32'h66;
        i_ldst_byte_en = 4'hF;
        i_ldst_rd      = 1'b1;
        i_ldst_wr      = 1'b1;
        cyc();
        i_ldst_rd = 1'b0;
        i_ldst_wr = 1'b0;
        chk("rdwr_hold", o_ldst_rddata, 32'h55);
        repeat (3) cyc();
        chk("idle_hold", o_ldst_rddata, 32'h55);
        ld_read(32'h0);
        chk("rdwr_applied", o_ldst_rddata, 32'h66);
        chk("pc_hold", o_pc_rddata, 32'h55);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cpu_mem_mmio.md
Name: cpu_mem_mmio

Overview:
Memory subsystem that sits directly downstream of the registered CPU memory-port wrapper. It serves the CPU's read-only instruction port and its read/write load-store port from one shared dual-port word RAM. It also decodes a small memory-mapped I/O window on the load-store port, containing a GPIO register, a free-running cycle counter and a sticky status register. Both ports have a fixed 1-cycle read latency and no wait states.

Parameters:
IW, 32, data/address width
MEM_WORDS, 2048, RAM depth in 32-bit words (power of two); AW = log2(MEM_WORDS)
MMIO_BASE, 32'h0000_A000, base byte address of MMIO window (16-byte aligned)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset
i_pc_addr  in  IW  instruction fetch byte address
i_pc_rd  in  1  fetch read strobe
i_pc_byte_en  in  4  accepted; ignored (always full word)
o_pc_rddata  out  IW  fetch data, valid cycle after i_pc_rd
i_ldst_addr  in  IW  load/store byte address
i_ldst_rd  in  1  load strobe
i_ldst_wr  in  1  store strobe
i_ldst_wrdata  in  IW  store data
i_ldst_byte_en  in  4  store lane enables; bit n = bits [8n+7:8n]
o_ldst_rddata  out  IW  load data, valid cycle after i_ldst_rd
o_gpio  out  IW  GPIO register contents

Behaviour:
- Reset (reset=0, async), forced while asserted:
  - o_pc_rddata = 0, o_ldst_rddata = 0, o_gpio = 0.
  - Cycle counter = 0, status = 0, registered source select = RAM.
  - RAM contents are not reset.
  - A read in flight when reset asserts is discarded; first post-reset output is 0.
- Addressing:
  - RAM word index = addr[AW+1:2]; addr[1:0] ignored.
  - Addresses below MMIO_BASE that exceed the RAM size alias modulo MEM_WORDS.
  - PC port always addresses RAM, never MMIO.
  - Load-store port selects MMIO when MMIO_BASE <= addr < MMIO_BASE+16; otherwise RAM.
- Reads:
  - Data appears on the rddata output at the first clk edge after the strobe cycle.
  - Each rddata output holds its last value in cycles with no strobe.
  - The ldst port registers its source select (RAM / MMIO offset) alongside the address and muxes on the output side.
- Writes:
  - Take effect at the clk edge of the strobe cycle, per enabled byte lane only.
  - byte_en = 0 with wr = 1 is a no-op and does not set status.
- ldst rd and wr asserted together: the write is performed, the read is ignored, o_ldst_rddata holds.
- Same-word collision (PC read and ldst write in the same cycle): PC returns old data (read-before-write); the new data is visible from the next read.
- MMIO map (offset from MMIO_BASE):
  - 0x0 GPIO: RW, byte-enabled; o_gpio updates the cycle after the write.
  - 0x4 CYCLE: 32-bit counter, +1 every clk, wraps 0xFFFFFFFF->0.
    - A read returns the value held in the strobe cycle.
    - A write (any lane) loads 0 at that edge, so the next cycle's value is 0 and counting resumes from there.
    - Write data is ignored.
  - 0x8 reserved: reads 0; a read or write sets STATUS[1].
  - 0xC STATUS: bit0 = write attempted to CYCLE (sticky); bit1 = access to reserved offset (sticky); bits[31:2] = 0.
    - Writing 1 to a bit clears it.
    - If a set event and a clear of the same bit coincide, set wins.
- Arithmetic: the counter is modulo 2^32; no other arithmetic.

Test Plan:
- Reset check: hold reset=0 for 3 cycles mid-read, release -> both rddata = 0, o_gpio = 0, CYCLE read in the first post-reset cycle = 0; RAM preloaded with 0xDEADBEEF at word 5 survives.
- Byte-enable store: write 0x11223344 full word to 0x14, then 0xAABBCCDD with byte_en=4'b0101 -> ldst read of 0x14 returns 0x11BB33DD one cycle later; PC fetch of 0x14 returns the same.
- Collision: PC read and ldst write 0xCAFEF00D to word 8 in the same cycle, old value 0x0 -> PC returns 0x0; PC read next cycle returns 0xCAFEF00D.
- Counter: write CYCLE at cycle t, read CYCLE at t+10 -> returns 9; STATUS read -> 0x1; write STATUS 0x1 -> STATUS read returns 0x0.
- GPIO/reserved: write 0x000000FF to GPIO with byte_en=4'b0001 -> o_gpio = 0xFF next cycle; read MMIO_BASE+0x8 -> returns 0, STATUS = 0x2.
- Alias/rd+wr: write 0x55 to byte addr 4*MEM_WORDS+0 -> word 0 reads 0x55; assert rd and wr together -> rddata unchanged, write applied.
